match_referee: RTL and testbench
================================

// Module: match_referee
// PURPOSE
// Match-level referee for the pong game. Sits directly upstream of ball_control:
// - consumes its per-point events;
// - keeps both scores and decides the winner;
// - rotates the server;
// - issues the one-cycle serve pulse that releases the ball from START.
// Scores feed the score renderer; game_over/winner feed the screen FSM.
// PARAMETERS
// WIN_POINTS        11   points needed to win (requires MIN_LEAD)
// MIN_LEAD          2    required lead at/after WIN_POINTS
// SERVES_PER_TURN   2    total points played before server toggles
// PAUSE_FRAMES      60   frames frozen after a point before serve allowed
// GAMEOVER_FRAMES   180  frames game_over is held before new match
// PORTS
// clk65MHz         in   1  system clock
// rst_n            in   1  reset; asynchronous, active-low
// end_of_frame     in   1  one-cycle pulse per video frame
// screen_idle      in   1  menu/idle screen active (level)
// screen_multi     in   1  1 = two players, 0 = single player
// point_p1         in   1  one-cycle pulse: player 1 won the rally
// point_p2         in   1  one-cycle pulse: player 2 won the rally
// serve_btn        in   1  serve key, already synchronised (level)
// serve            out  1  one-cycle pulse to ball_control
// server           out  1  0 = player 1 serves, 1 = player 2
// points_player_1  out  4  player 1 score
// points_player_2  out  4  player 2 score
// game_over        out  1  high while in GAME_OVER
// winner           out  2  00 none, 01 player 1, 10 player 2
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; all outputs 0; frame counter 0; serve_btn history 0.
// - All outputs registered. Only clk65MHz edges change state after reset release.
// - States: IDLE, WAIT_SERVE, RALLY, PAUSE, GAME_OVER.
// - screen_idle=1 in any state forces IDLE next cycle. Scores, winner and server are cleared.
//   This highest-priority rule also applies mid-rally and mid-pause.
// - IDLE -> WAIT_SERVE when screen_idle=0.
// - WAIT_SERVE, multi mode: serve_btn rising edge (btn & ~btn_q) -> serve=1 for exactly 1 cycle
//   on the next edge; state RALLY.
// - WAIT_SERVE, single mode: serve is issued automatically on the first cycle in WAIT_SERVE;
//   state RALLY.
// - RALLY, point_pX alone: scoring player's count +1, registered 1 cycle after the pulse.
//   Winner is checked on the incremented value in the same cycle.
//   - Win -> GAME_OVER and winner set on the same edge.
//   - No win -> PAUSE.
// - RALLY, point_p1 & point_p2 together: both ignored, stay RALLY.
// - Point pulses outside RALLY are ignored. serve_btn outside WAIT_SERVE is ignored; an edge
//   seen during PAUSE is not remembered.
// - Win rule: score >= WIN_POINTS and score - other >= MIN_LEAD.
//   A score reaching 15 wins unconditionally; scores saturate at 15, no wrap.
// - Server: a 2-bit points-played counter increments per scored point.
//   On reaching SERVES_PER_TURN it clears and server toggles, effective for the next serve.
// - PAUSE: counts end_of_frame pulses. After PAUSE_FRAMES pulses -> WAIT_SERVE, counter cleared.
// - GAME_OVER: game_over=1. After GAMEOVER_FRAMES end_of_frame pulses:
//   - scores, winner and server clear;
//   - game_over=0;
//   - state WAIT_SERVE.
// - Frame counter width is $clog2(max(PAUSE_FRAMES, GAMEOVER_FRAMES)+1).
//   It clears on every state change.
// STRUCTURE
// - game_pkg: referee_state_t enum (3-bit); WINNER_NONE/P1/P2 constants; SCORE_MAX=15.
// - One sub-module, frame_timer: inputs clk65MHz, rst_n, clear, end_of_frame, target;
//   output done is a 1-cycle pulse when count==target.
// - Top: FSM, score/serve-rotation registers, serve_btn edge detect, win comparator.
// TESTING
// 1. Reset release, screen_idle=0, multi: WAIT_SERVE. serve_btn 0->1 -> serve high 1 cycle, next edge.
// 2. Single mode: point_p1 -> points_player_1=1 after 1 cycle.
//    No serve for 60 frames, then auto serve pulse.
// 3. Scores 10:10, p1 scores -> 11:10, no win.
//    p1 scores -> 12:10, game_over=1, winner=01.
//    180 frames later scores 0:0, game_over=0.
// 4. Simultaneous point_p1 & point_p2 in RALLY -> scores unchanged, stays RALLY, no serve.
// 5. Server rotation: 4 points -> server 0,0,1,1,0 at each successive serve.
//    Scores 14:14, next point -> 15:14 win (saturation rule).
// 6. screen_idle=1 mid-PAUSE -> IDLE next cycle, scores 0.
//    rst_n low mid-RALLY -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/match_referee_pkg.sv
// Shared types, constants and helpers for the pong match referee.
package match_referee_pkg;

    // Referee FSM states
    typedef enum logic [2:0] {
        StIdle,
        StWaitServe,
        StRally,
        StPause,
        StGameOver
    } referee_state_t;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;

    localparam logic [3:0] SCORE_MAX = 4'd15;

    localparam int unsigned DEF_WIN_POINTS      = 11;
    localparam int unsigned DEF_MIN_LEAD        = 2;
    localparam int unsigned DEF_SERVES_PER_TURN = 2;
    localparam int unsigned DEF_PAUSE_FRAMES    = 60;
    localparam int unsigned DEF_GAMEOVER_FRAMES = 180;

    // Score increment that sticks at SCORE_MAX instead of wrapping
    function automatic logic [3:0] sat_inc(logic [3:0] v);
        return (v == SCORE_MAX) ? v : v + 4'd1;
    endfunction

    // A score wins when it reaches the target with enough lead, or hits the ceiling
    function automatic logic is_win(logic [3:0] score, logic [3:0] other,
                                    int unsigned win_points, int unsigned min_lead);
        int unsigned s;
        int unsigned o;
        s = 32'(score);
        o = 32'(other);
        return (score == SCORE_MAX) || ((s >= win_points) && (s >= o + min_lead));
    endfunction

endpackage

// File: rtl/match_referee_if.sv
// Signal bundle between the game screen logic and the match referee.
interface match_referee_if;
    logic       end_of_frame;
    logic       screen_idle;
    logic       screen_multi;
    logic       point_p1;
    logic       point_p2;
    logic       serve_btn;
    logic       serve;
    logic       server;
    logic [3:0] points_player_1;
    logic [3:0] points_player_2;
    logic       game_over;
    logic [1:0] winner;

    // Game side: drives events, observes referee decisions
    modport master (
        output end_of_frame, screen_idle, screen_multi, point_p1, point_p2, serve_btn,
        input  serve, server, points_player_1, points_player_2, game_over, winner
    );

    // Referee side
    modport slave (
        input  end_of_frame, screen_idle, screen_multi, point_p1, point_p2, serve_btn,
        output serve, server, points_player_1, points_player_2, game_over, winner
    );
endinterface

// File: rtl/match_referee_frame_timer.sv
// Counts end_of_frame pulses up to a target; done flags arrival at the target.
// The owner clears the counter on the state change that done triggers, so done is
// seen for a single cycle. The count holds at target rather than running past it.
module frame_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk65MHz,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             end_of_frame,
    input  logic [Width-1:0] target,
    output logic             done
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    // Next count: clear wins, otherwise step on each frame pulse until target
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (end_of_frame && (count_q != target)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == target);

endmodule

// File: rtl/match_referee.sv
// Match referee: scores points, decides the winner, rotates the server and issues
// the one-cycle serve pulse that releases the ball.
module match_referee
    import match_referee_pkg::*;
#(
    parameter int unsigned WIN_POINTS      = DEF_WIN_POINTS,
    parameter int unsigned MIN_LEAD        = DEF_MIN_LEAD,
    // Points-played counter is 2 bits wide, so this must stay within 1..3
    parameter int unsigned SERVES_PER_TURN = DEF_SERVES_PER_TURN,
    parameter int unsigned PAUSE_FRAMES    = DEF_PAUSE_FRAMES,
    parameter int unsigned GAMEOVER_FRAMES = DEF_GAMEOVER_FRAMES
) (
    input  logic               clk65MHz,
    input  logic               rst_n,
    match_referee_if.slave     ref_io
);

    localparam int unsigned FrameMax =
        (PAUSE_FRAMES > GAMEOVER_FRAMES) ? PAUSE_FRAMES : GAMEOVER_FRAMES;
    localparam int unsigned FrameW = $clog2(FrameMax + 1);

    localparam logic [FrameW-1:0] PauseTarget    = FrameW'(PAUSE_FRAMES);
    localparam logic [FrameW-1:0] GameOverTarget = FrameW'(GAMEOVER_FRAMES);
    localparam logic [1:0]        TurnPoints     = 2'(SERVES_PER_TURN);

    referee_state_t state_q, state_d;

    logic       btn_q;
    logic [3:0] score1_q, score1_d;
    logic [3:0] score2_q, score2_d;
    logic [1:0] winner_q, winner_d;
    logic       server_q, server_d;
    logic [1:0] played_q, played_d;
    logic       serve_q, serve_d;
    logic       game_over_q, game_over_d;

    logic              btn_rise;
    logic              p1_only;
    logic              p2_only;
    logic [3:0]        score1_inc;
    logic [3:0]        score2_inc;
    logic              p1_wins;
    logic              p2_wins;
    logic              serve_now;
    logic              timer_clear;
    logic              timer_eof;
    logic              timer_done;
    logic [FrameW-1:0] timer_target;
    logic [1:0]        played_inc;

    assign btn_rise   = ref_io.serve_btn & ~btn_q;
    assign p1_only    = ref_io.point_p1 & ~ref_io.point_p2;
    assign p2_only    = ref_io.point_p2 & ~ref_io.point_p1;
    assign score1_inc = sat_inc(score1_q);
    assign score2_inc = sat_inc(score2_q);
    assign p1_wins    = is_win(score1_inc, score2_q, WIN_POINTS, MIN_LEAD);
    assign p2_wins    = is_win(score2_inc, score1_q, WIN_POINTS, MIN_LEAD);
    assign played_inc = played_q + 2'd1;

    // Single player serves automatically; two players wait for a fresh key press
    assign serve_now = ~ref_io.screen_multi | btn_rise;

    // Frame pulses only matter while a timed state is active
    assign timer_eof    = ref_io.end_of_frame &
                          ((state_q == StPause) || (state_q == StGameOver));
    assign timer_target = (state_q == StGameOver) ? GameOverTarget : PauseTarget;
    assign timer_clear  = (state_d != state_q);

    frame_timer #(
        .Width        (FrameW)
    ) u_frame_timer (
        .clk65MHz     (clk65MHz),
        .rst_n        (rst_n),
        .clear        (timer_clear),
        .end_of_frame (timer_eof),
        .target       (timer_target),
        .done         (timer_done)
    );

    // FSM state register
    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; the idle screen overrides everything
    always_comb begin
        state_d = state_q;
        if (ref_io.screen_idle) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: state_d = StWaitServe;
                StWaitServe: begin
                    if (serve_now) state_d = StRally;
                end
                StRally: begin
                    if (p1_only) begin
                        state_d = p1_wins ? StGameOver : StPause;
                    end else if (p2_only) begin
                        state_d = p2_wins ? StGameOver : StPause;
                    end
                end
                StPause: begin
                    if (timer_done) state_d = StWaitServe;
                end
                StGameOver: begin
                    if (timer_done) state_d = StWaitServe;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs: next values of scores, serve rotation, winner and pulses
    always_comb begin
        score1_d    = score1_q;
        score2_d    = score2_q;
        winner_d    = winner_q;
        server_d    = server_q;
        played_d    = played_q;
        game_over_d = game_over_q;
        serve_d     = 1'b0;

        if (ref_io.screen_idle) begin
            score1_d    = '0;
            score2_d    = '0;
            winner_d    = WINNER_NONE;
            server_d    = 1'b0;
            played_d    = '0;
            game_over_d = 1'b0;
        end else begin
            case (state_q)
                StWaitServe: serve_d = serve_now;
                StRally: begin
                    if (p1_only || p2_only) begin
                        // Server change takes effect at the next serve
                        if (played_inc == TurnPoints) begin
                            played_d = '0;
                            server_d = ~server_q;
                        end else begin
                            played_d = played_inc;
                        end
                    end
                    if (p1_only) begin
                        score1_d = score1_inc;
                        if (p1_wins) begin
                            winner_d    = WINNER_P1;
                            game_over_d = 1'b1;
                        end
                    end else if (p2_only) begin
                        score2_d = score2_inc;
                        if (p2_wins) begin
                            winner_d    = WINNER_P2;
                            game_over_d = 1'b1;
                        end
                    end
                end
                StGameOver: begin
                    if (timer_done) begin
                        score1_d    = '0;
                        score2_d    = '0;
                        winner_d    = WINNER_NONE;
                        server_d    = 1'b0;
                        played_d    = '0;
                        game_over_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs and serve key history
    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            btn_q       <= 1'b0;
            score1_q    <= '0;
            score2_q    <= '0;
            winner_q    <= WINNER_NONE;
            server_q    <= 1'b0;
            played_q    <= '0;
            serve_q     <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            btn_q       <= ref_io.serve_btn;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            winner_q    <= winner_d;
            server_q    <= server_d;
            played_q    <= played_d;
            serve_q     <= serve_d;
            game_over_q <= game_over_d;
        end
    end

    assign ref_io.serve           = serve_q;
    assign ref_io.server          = server_q;
    assign ref_io.points_player_1 = score1_q;
    assign ref_io.points_player_2 = score2_q;
    assign ref_io.game_over       = game_over_q;
    assign ref_io.winner          = winner_q;

endmodule

// File: tb/tb_match_referee.sv
// Bench for match_referee: vector table, directed match scenarios, random play
// against a rule-level model of the referee.
module tb_match_referee;

    localparam int WIN_PTS  = 11;
    localparam int LEAD     = 2;
    localparam int TURN     = 2;
    localparam int PAUSE_F  = 60;
    localparam int GO_F     = 180;
    localparam int MAXSCORE = 15;

    localparam int PH_IDLE  = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_RALLY = 2;
    localparam int PH_PAUSE = 3;
    localparam int PH_OVER  = 4;

    logic clk;
    logic rst_n;

    match_referee_if bus ();

    match_referee dut (
        .clk65MHz (clk),
        .rst_n    (rst_n),
        .ref_io   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model state
    int m_phase, m_s1, m_s2, m_winner, m_played, m_frames;
    bit m_server, m_serve, m_go, m_btn_prev;

    typedef struct {
        bit          idle, multi, btn, p1, p2, eof;
        logic [12:0] exp;   // {serve, server, p1 score, p2 score, game_over, winner}
    } vec_t;

    vec_t vecs[14];
    bit   srv_exp[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    function automatic logic [12:0] dut_out();
        return {bus.serve, bus.server, bus.points_player_1, bus.points_player_2,
                bus.game_over, bus.winner};
    endfunction

    function automatic logic [12:0] model_out();
        return {m_serve, m_server, 4'(m_s1), 4'(m_s2), m_go, 2'(m_winner)};
    endfunction

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE; m_s1 = 0; m_s2 = 0; m_winner = 0; m_played = 0;
        m_frames = 0; m_server = 0; m_serve = 0; m_go = 0; m_btn_prev = 0;
    endtask

    task automatic model_clear_match();
        m_s1 = 0; m_s2 = 0; m_winner = 0; m_server = 0; m_played = 0; m_go = 0;
    endtask

    task automatic model_award(input int who);
        int mine, other;
        mine  = (who == 1) ? m_s1 : m_s2;
        other = (who == 1) ? m_s2 : m_s1;
        if (mine < MAXSCORE) mine++;
        if (who == 1) m_s1 = mine; else m_s2 = mine;
        m_played++;
        if (m_played == TURN) begin
            m_played = 0;
            m_server = ~m_server;
        end
        if (mine == MAXSCORE || (mine >= WIN_PTS && mine - other >= LEAD)) begin
            m_phase  = PH_OVER;
            m_go     = 1;
            m_winner = who;
        end else begin
            m_phase = PH_PAUSE;
        end
        m_frames = 0;
    endtask

    // One clock edge of the referee rules applied to the current inputs
    task automatic model_step();
        bit rise;
        rise       = bus.serve_btn && !m_btn_prev;
        m_btn_prev = bus.serve_btn;
        m_serve    = 0;
        if (bus.screen_idle) begin
            model_clear_match();
            m_phase  = PH_IDLE;
            m_frames = 0;
        end else begin
            case (m_phase)
                PH_IDLE: m_phase = PH_WAIT;
                PH_WAIT: if (!bus.screen_multi || rise) begin
                    m_serve = 1;
                    m_phase = PH_RALLY;
                end
                PH_RALLY: if (bus.point_p1 != bus.point_p2) model_award(bus.point_p1 ? 1 : 2);
                PH_PAUSE: begin
                    if (m_frames == PAUSE_F) begin
                        m_phase  = PH_WAIT;
                        m_frames = 0;
                    end else if (bus.end_of_frame) m_frames++;
                end
                default: begin
                    if (m_frames == GO_F) begin
                        model_clear_match();
                        m_phase  = PH_WAIT;
                        m_frames = 0;
                    end else if (bus.end_of_frame) m_frames++;
                end
            endcase
        end
    endtask

    task automatic step(input bit idle, input bit multi, input bit btn,
                        input bit p1, input bit p2, input bit eof);
        bus.screen_idle  = idle;
        bus.screen_multi = multi;
        bus.serve_btn    = btn;
        bus.point_p1     = p1;
        bus.point_p2     = p2;
        bus.end_of_frame = eof;
        @(posedge clk);
        model_step();
        #1;
        check("model", dut_out(), model_out());
    endtask

    task automatic do_reset();
        bus.screen_idle = 1'b1; bus.screen_multi = 1'b0; bus.serve_btn = 1'b0;
        bus.point_p1 = 1'b0; bus.point_p2 = 1'b0; bus.end_of_frame = 1'b0;
        rst_n = 1'b0;
        #2;
        check("reset_outputs", dut_out(), 13'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic do_serve(input bit multi);
        if (multi) begin
            step(0, 1, 0, 0, 0, 0);
            step(0, 1, 1, 0, 0, 0);
        end else begin
            step(0, 0, 0, 0, 0, 0);
        end
        check("serve_pulse", 13'(bus.serve), 13'd1);
    endtask

    task automatic do_point(input bit multi, input int who);
        step(0, multi, 0, who == 1, who == 2, 0);
    endtask

    task automatic finish_pause(input bit multi);
        for (int i = 0; i < 200 && m_phase == PH_PAUSE; i++) step(0, multi, 0, 0, 0, 1);
        if (m_phase == PH_PAUSE) begin
            n_vec++;
            n_err++;
            $display("FAIL pause_bound: got still paused expected wait-serve");
        end
    endtask

    initial begin
        bit r_multi, r_btn, rp1, rp2;
        int r;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        model_reset();

        // Cycle table: serve edge, simultaneous points, ignored events, idle clear
        vecs[0]  = '{0, 1, 0, 0, 0, 0, 13'h0000};
        vecs[1]  = '{0, 1, 1, 0, 0, 0, 13'h1000};
        vecs[2]  = '{0, 1, 1, 0, 0, 0, 13'h0000};
        vecs[3]  = '{0, 1, 0, 1, 1, 0, 13'h0000};
        vecs[4]  = '{0, 1, 0, 0, 0, 1, 13'h0000};
        vecs[5]  = '{0, 1, 0, 0, 1, 0, 13'h0008};
        vecs[6]  = '{0, 1, 0, 1, 0, 0, 13'h0008};
        vecs[7]  = '{0, 1, 1, 0, 0, 0, 13'h0008};
        vecs[8]  = '{1, 1, 0, 0, 0, 0, 13'h0000};
        vecs[9]  = '{0, 1, 1, 0, 0, 0, 13'h0000};
        vecs[10] = '{0, 1, 1, 0, 0, 0, 13'h0000};
        vecs[11] = '{0, 1, 0, 0, 0, 0, 13'h0000};
        vecs[12] = '{0, 1, 1, 0, 0, 0, 13'h1000};
        vecs[13] = '{0, 1, 0, 1, 0, 0, 13'h0080};

        do_reset();
        foreach (vecs[i]) begin
            step(vecs[i].idle, vecs[i].multi, vecs[i].btn, vecs[i].p1, vecs[i].p2,
                 vecs[i].eof);
            check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
        end

        // Single player: auto serve, point, 60-frame freeze, auto serve again
        do_reset();
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("single_auto_serve", 13'(bus.serve), 13'd1);
        do_point(0, 1);
        check("single_p1_score", 13'(bus.points_player_1), 13'd1);
        for (int i = 0; i < PAUSE_F; i++) step(0, 0, 0, 0, 0, 1);
        check("pause_no_serve", 13'(bus.serve), 13'd0);
        step(0, 0, 0, 0, 0, 0);
        check("pause_exit_no_serve", 13'(bus.serve), 13'd0);
        step(0, 0, 0, 0, 0, 0);
        check("single_reserve", 13'(bus.serve), 13'd1);

        // Two players to 10:10, then 11:10 no win, 12:10 win, then game-over timeout
        do_reset();
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            do_serve(1);
            do_point(1, (i % 2 == 0) ? 1 : 2);
            finish_pause(1);
        end
        check("deuce_10_10", {5'd0, bus.points_player_1, bus.points_player_2}, 13'h00AA);
        do_serve(1);
        do_point(1, 1);
        check("p1_11_10", {5'd0, bus.points_player_1, bus.points_player_2}, 13'h00BA);
        check("no_win_11_10", {10'd0, bus.game_over, bus.winner}, 13'd0);
        finish_pause(1);
        do_serve(1);
        do_point(1, 1);
        check("p1_12_10", {5'd0, bus.points_player_1, bus.points_player_2}, 13'h00CA);
        check("win_12_10", {10'd0, bus.game_over, bus.winner}, 13'd5);
        for (int i = 0; i < GO_F; i++) step(0, 1, 0, 0, 0, 1);
        check("game_over_held", 13'(bus.game_over), 13'd1);
        step(0, 1, 0, 0, 0, 0);
        check("game_over_cleared", dut_out(), 13'd0);

        // Server rotation over five serves, then saturation win at 15:14
        do_reset();
        step(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            do_serve(1);
            check($sformatf("server_at_serve%0d", k), 13'(bus.server), 13'(srv_exp[k]));
            if (k < 4) begin
                do_point(1, (k % 2 == 0) ? 1 : 2);
                finish_pause(1);
            end
        end
        for (int j = 0; j < 24; j++) begin
            if (j > 0) do_serve(1);
            do_point(1, (j % 2 == 0) ? 1 : 2);
            finish_pause(1);
        end
        check("tie_14_14", {5'd0, bus.points_player_1, bus.points_player_2}, 13'h00EE);
        do_serve(1);
        do_point(1, 1);
        check("sat_15_14", {5'd0, bus.points_player_1, bus.points_player_2}, 13'h00FE);
        check("sat_win", {10'd0, bus.game_over, bus.winner}, 13'd5);

        // Idle screen in the middle of a pause, then asynchronous reset mid-rally
        step(1, 1, 0, 0, 0, 0);
        check("idle_from_game_over", dut_out(), 13'd0);
        step(0, 1, 0, 0, 0, 0);
        do_serve(1);
        do_point(1, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0);
        check("idle_mid_pause", dut_out(), 13'd0);
        step(0, 1, 0, 0, 0, 0);
        do_serve(1);
        do_point(1, 2);
        finish_pause(1);
        do_serve(1);
        step(0, 1, 0, 0, 0, 0);
        check("pre_reset_score", 13'(bus.points_player_2), 13'd1);
        #3 rst_n = 1'b0;
        #1 check("async_reset_mid_rally", dut_out(), 13'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Random play against the model
        r_multi = 1'b1;
        r_btn   = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            if ($urandom_range(0, 999) == 0) r_multi = ~r_multi;
            if ($urandom_range(0, 3) == 0) r_btn = ~r_btn;
            r   = int'($urandom_range(0, 15));
            rp1 = 1'b0;
            rp2 = 1'b0;
            if ((i % 6000) < 3000) begin
                if (r <= 1) rp1 = 1'b1;
                else if (r == 2) rp2 = 1'b1;
                else if (r == 3) begin rp1 = 1'b1; rp2 = 1'b1; end
            end else begin
                if (r == 0) rp1 = 1'b1;
                else if (r == 1) rp2 = 1'b1;
                else if (r == 2) begin rp1 = 1'b1; rp2 = 1'b1; end
            end
            step($urandom_range(0, 7999) == 0, r_multi, r_btn, rp1, rp2,
                 $urandom_range(0, 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
